// File: rtl/outlayer_argmax.sv
// Output layer: stores a NUM_CLASS x LENGHT_H signed weight matrix, runs one
// multiply-accumulate per cycle over a captured hidden vector and reports the arg-max class.
module outlayer_argmax #(
  parameter int LENGHT_H  = 8,
  parameter int WIDTH_O   = 7,
  parameter int WIDTH_W   = 9,
  parameter int NUM_CLASS = 4,
  parameter int WIDTH_IDX = 2,
  parameter int WIDTH_ACC = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          w_load,
  input  logic [WIDTH_W-1:0]            w_i,
  output logic                          w_loaded,
  input  logic                          h_valid,
  input  logic [LENGHT_H*WIDTH_O-1:0]   h_in,
  output logic                          h_ready,
  output logic                          class_valid,
  output logic [WIDTH_IDX-1:0]          class_idx,
  output logic [WIDTH_ACC-1:0]          class_score
);

  localparam int DEPTH = NUM_CLASS * LENGHT_H;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int JW    = (LENGHT_H > 1) ? $clog2(LENGHT_H) : 1;
  localparam int PW    = WIDTH_W + WIDTH_O + 1;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                        state_reg;
  logic [WIDTH_W-1:0]            mem [DEPTH];
  logic [WIDTH_W-1:0]            rd_data_reg;
  logic [AW-1:0]                 w_addr_reg;
  logic                          w_loaded_reg;
  logic [AW-1:0]                 mac_addr_reg;
  logic [AW-1:0]                 rd_addr;
  logic [JW-1:0]                 j_reg;
  logic [WIDTH_IDX-1:0]          c_reg;
  logic [LENGHT_H*WIDTH_O-1:0]   h_reg;
  logic [WIDTH_O-1:0]            h_arr [LENGHT_H];
  logic signed [WIDTH_ACC-1:0]   acc_reg;
  logic signed [WIDTH_ACC-1:0]   best_score_reg;
  logic [WIDTH_IDX-1:0]          best_idx_reg;
  logic                          class_valid_reg;
  logic [WIDTH_IDX-1:0]          class_idx_reg;
  logic [WIDTH_ACC-1:0]          class_score_reg;

  logic                          wr_en;
  logic                          j_last;
  logic                          mac_last;
  logic [WIDTH_O-1:0]            h_cur;
  logic signed [PW-1:0]          prod;
  logic signed [WIDTH_ACC-1:0]   prod_ext;
  logic signed [WIDTH_ACC-1:0]   sum_next;
  logic                          take_next;
  logic signed [WIDTH_ACC-1:0]   best_score_next;
  logic [WIDTH_IDX-1:0]          best_idx_next;

  genvar gi;
  generate
    for (gi = 0; gi < LENGHT_H; gi++) begin : g_h_unpack
      assign h_arr[gi] = h_reg[gi*WIDTH_O +: WIDTH_O];
    end
  endgenerate

  assign wr_en    = (state_reg == IDLE) && w_load && !rst;
  assign j_last   = (j_reg == JW'(LENGHT_H - 1));
  assign mac_last = (mac_addr_reg == AW'(DEPTH - 1));
  assign h_ready  = (state_reg == IDLE) && w_loaded_reg && !w_load;

  // Read one address ahead so the registered weight lines up with its MAC cycle;
  // in IDLE the first weight is kept prefetched for an immediate start.
  always_comb begin
    rd_addr = '0;
    if (state_reg == MAC && !mac_last)
      rd_addr = mac_addr_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[w_addr_reg] <= w_i;
    rd_data_reg <= mem[rd_addr];
  end

  always_comb begin
    h_cur           = h_arr[j_reg];
    prod            = $signed(rd_data_reg) * $signed({1'b0, h_cur});
    prod_ext        = {{(WIDTH_ACC-PW){prod[PW-1]}}, prod};
    sum_next        = ((j_reg == '0) ? '0 : acc_reg) + prod_ext;
    take_next       = (c_reg == '0) || (sum_next > best_score_reg);
    best_score_next = take_next ? sum_next : best_score_reg;
    best_idx_next   = take_next ? c_reg : best_idx_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      w_addr_reg      <= '0;
      w_loaded_reg    <= 1'b0;
      mac_addr_reg    <= '0;
      j_reg           <= '0;
      c_reg           <= '0;
      h_reg           <= '0;
      acc_reg         <= '0;
      best_score_reg  <= '0;
      best_idx_reg    <= '0;
      class_valid_reg <= 1'b0;
      class_idx_reg   <= '0;
      class_score_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          class_valid_reg <= 1'b0;
          if (w_load) begin
            if (w_addr_reg == AW'(DEPTH - 1)) begin
              w_addr_reg   <= '0;
              w_loaded_reg <= 1'b1;
            end else begin
              w_addr_reg <= w_addr_reg + 1'b1;
            end
          end else if (h_valid && h_ready) begin
            h_reg        <= h_in;
            mac_addr_reg <= '0;
            j_reg        <= '0;
            c_reg        <= '0;
            state_reg    <= MAC;
          end
        end
        MAC: begin
          acc_reg      <= sum_next;
          mac_addr_reg <= mac_addr_reg + 1'b1;
          if (j_last) begin
            j_reg          <= '0;
            c_reg          <= c_reg + 1'b1;
            best_score_reg <= best_score_next;
            best_idx_reg   <= best_idx_next;
          end else begin
            j_reg <= j_reg + 1'b1;
          end
          if (mac_last) begin
            class_valid_reg <= 1'b1;
            class_idx_reg   <= best_idx_next;
            class_score_reg <= best_score_next;
            state_reg       <= DONE;
          end
        end
        DONE: begin
          class_valid_reg <= 1'b0;
          state_reg       <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign w_loaded    = w_loaded_reg;
  assign class_valid = class_valid_reg;
  assign class_idx   = class_idx_reg;
  assign class_score = class_score_reg;

endmodule

// File: tb/tb_outlayer_argmax.sv
// Directed and randomized checks of outlayer_argmax against a plain-arithmetic
// matrix-vector / arg-max model.
module tb_outlayer_argmax;
  localparam int LH = 8, WO = 7, WW = 9, NC = 4, WI = 2, WA = 20;
  localparam int DEPTH = NC * LH;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 w_load = 1'b0;
  logic [WW-1:0]        w_i = '0;
  logic                 w_loaded;
  logic                 h_valid = 1'b0;
  logic [LH*WO-1:0]     h_in = '0;
  logic                 h_ready;
  logic                 class_valid;
  logic [WI-1:0]        class_idx;
  logic signed [WA-1:0] class_score;

  int n_cmp = 0;
  int n_mis = 0;
  int w_model [DEPTH];
  int wptr = 0;
  int wset [DEPTH];

  outlayer_argmax #(.LENGHT_H(LH), .WIDTH_O(WO), .WIDTH_W(WW), .NUM_CLASS(NC),
                    .WIDTH_IDX(WI), .WIDTH_ACC(WA)) dut (
    .clk(clk), .rst(rst), .w_load(w_load), .w_i(w_i), .w_loaded(w_loaded),
    .h_valid(h_valid), .h_in(h_in), .h_ready(h_ready), .class_valid(class_valid),
    .class_idx(class_idx), .class_score(class_score));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [LH*WO-1:0] rand_h();
    return (LH*WO)'({$urandom(), $urandom()});
  endfunction

  function automatic logic [LH*WO-1:0] const_h(input int v);
    logic [LH*WO-1:0] h;
    h = '0;
    for (int j = 0; j < LH; j++) h[j*WO +: WO] = WO'(v);
    return h;
  endfunction

  // Plain matrix-vector product followed by first-maximum selection.
  task automatic ref_model(input logic [LH*WO-1:0] h, output int idx, output longint score);
    longint s;
    idx = 0;
    score = 0;
    for (int c = 0; c < NC; c++) begin
      s = 0;
      for (int j = 0; j < LH; j++)
        s += longint'(w_model[c*LH + j]) * longint'(h[j*WO +: WO]);
      if (c == 0 || s > score) begin
        score = s;
        idx = c;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    w_load = 1'b0;
    h_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wptr = 0;
  endtask

  task automatic write_weight(input int val);
    @(negedge clk);
    w_load = 1'b1;
    w_i = WW'(val);
    w_model[wptr] = val;
    wptr = (wptr + 1) % DEPTH;
  endtask

  task automatic load_set(input string tag);
    for (int i = 0; i < DEPTH; i++) write_weight(wset[i]);
    @(negedge clk);
    w_load = 1'b0;
    #1;
    chk({tag, "_w_loaded"}, 64'(w_loaded), 1);
    chk({tag, "_h_ready"}, 64'(h_ready), 1);
  endtask

  task automatic run_vector(input string tag, input logic [LH*WO-1:0] h, input bit wload_mac);
    int exp_idx;
    longint exp_score;
    int cnt;
    bit seen;
    ref_model(h, exp_idx, exp_score);
    @(negedge clk);
    h_valid = 1'b1;
    h_in = h;
    #1;
    chk({tag, "_h_ready_idle"}, 64'(h_ready), 1);
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 40) begin
      @(negedge clk);
      cnt++;
      h_in = rand_h();
      if (cnt == 1 && wload_mac) begin
        w_load = 1'b1;
        w_i = WW'($urandom);
      end
      if (cnt == 5) chk({tag, "_h_ready_mac"}, 64'(h_ready), 0);
      if (class_valid === 1'b1) seen = 1'b1;
    end
    h_valid = 1'b0;
    w_load = 1'b0;
    chk({tag, "_latency"}, cnt, 33);
    chk({tag, "_idx"}, 64'(class_idx), exp_idx);
    chk({tag, "_score"}, 64'(class_score), exp_score);
    @(negedge clk);
    #1;
    chk({tag, "_valid_drop"}, 64'(class_valid), 0);
    chk({tag, "_idx_hold"}, 64'(class_idx), exp_idx);
    chk({tag, "_score_hold"}, 64'(class_score), exp_score);
    chk({tag, "_h_ready_back"}, 64'(h_ready), 1);
  endtask

  initial begin
    int nvalid;
    int nready;
    logic [LH*WO-1:0] h;

    // Reset state
    do_reset();
    #1;
    chk("rst_w_loaded", 64'(w_loaded), 0);
    chk("rst_h_ready", 64'(h_ready), 0);
    chk("rst_class_valid", 64'(class_valid), 0);
    chk("rst_class_idx", 64'(class_idx), 0);
    chk("rst_class_score", 64'(class_score), 0);

    // Vector offered with no weights loaded
    @(negedge clk);
    h_valid = 1'b1;
    h_in = const_h(5);
    #1;
    chk("noweights_h_ready", 64'(h_ready), 0);
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (class_valid !== 1'b0) nvalid++;
    end
    h_valid = 1'b0;
    chk("noweights_no_valid", nvalid, 0);

    // w(c,j) = c+1, h = 1: class 3 wins with 32
    for (int c = 0; c < NC; c++)
      for (int j = 0; j < LH; j++) wset[c*LH + j] = c + 1;
    load_set("ramp");
    run_vector("ramp", const_h(1), 1'b0);
    chk("ramp_idx_const", 64'(class_idx), 3);
    chk("ramp_score_const", 64'(class_score), 32);

    // All weights -256, h = 127: all classes tie, lowest index kept
    for (int i = 0; i < DEPTH; i++) wset[i] = -256;
    load_set("neg");
    run_vector("neg", const_h(127), 1'b0);
    chk("neg_idx_const", 64'(class_idx), 0);
    chk("neg_score_const", 64'(class_score), -260096);

    // Single non-zero weight w(2,5) = 10, h_5 = 7
    for (int i = 0; i < DEPTH; i++) wset[i] = 0;
    wset[2*LH + 5] = 10;
    load_set("sparse");
    h = '0;
    h[5*WO +: WO] = WO'(7);
    run_vector("sparse", h, 1'b0);
    chk("sparse_idx_const", 64'(class_idx), 2);
    chk("sparse_score_const", 64'(class_score), 70);

    // Write strobe and vector in the same IDLE cycle: write wins, no handshake
    @(negedge clk);
    w_load = 1'b1;
    w_i = WW'(100);
    w_model[wptr] = 100;
    wptr = (wptr + 1) % DEPTH;
    h_valid = 1'b1;
    h_in = const_h(3);
    #1;
    chk("collide_h_ready", 64'(h_ready), 0);
    @(negedge clk);
    w_load = 1'b0;
    h_valid = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (class_valid !== 1'b0) nvalid++;
    end
    chk("collide_no_valid", nvalid, 0);
    chk("collide_h_ready_after", 64'(h_ready), 1);
    for (int i = 1; i < DEPTH; i++) write_weight(int'($urandom_range(511)) - 256);
    @(negedge clk);
    w_load = 1'b0;
    run_vector("collide", const_h(3), 1'b0);

    // Randomized weights and vectors; some runs strobe w_load during MAC
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < DEPTH; i++) wset[i] = int'($urandom_range(511)) - 256;
      load_set("rand");
      run_vector("rand", rand_h(), t[0]);
      run_vector("rand2", rand_h(), 1'b0);
    end

    // Reset in the middle of a computation
    @(negedge clk);
    h_valid = 1'b1;
    h_in = rand_h();
    for (int i = 0; i < 10; i++) @(negedge clk);
    h_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_w_loaded", 64'(w_loaded), 0);
    chk("abort_h_ready", 64'(h_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    wptr = 0;
    nvalid = 0;
    nready = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (class_valid !== 1'b0) nvalid++;
      if (h_ready !== 1'b0) nready++;
    end
    chk("abort_no_valid", nvalid, 0);
    chk("abort_no_ready", nready, 0);
    chk("abort_score", 64'(class_score), 0);
    chk("abort_idx", 64'(class_idx), 0);
    for (int i = 0; i < DEPTH - 1; i++) write_weight(int'($urandom_range(511)) - 256);
    @(negedge clk);
    w_load = 1'b0;
    #1;
    chk("reload31_h_ready", 64'(h_ready), 0);
    chk("reload31_w_loaded", 64'(w_loaded), 0);
    write_weight(int'($urandom_range(511)) - 256);
    @(negedge clk);
    w_load = 1'b0;
    #1;
    chk("reload32_h_ready", 64'(h_ready), 1);
    chk("reload32_w_loaded", 64'(w_loaded), 1);
    run_vector("reload", rand_h(), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
